// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: Moore main FSM plus combinational ALU decoder.
// Drives every mux select and write enable of the multicycle datapath.
module mc_control_unit #(
    parameter int unsigned ADDI_EN = 1,
    parameter int unsigned J_EN    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] StFetch   = 4'd0;
    localparam logic [3:0] StDecode  = 4'd1;
    localparam logic [3:0] StMemAdr  = 4'd2;
    localparam logic [3:0] StMemRd   = 4'd3;
    localparam logic [3:0] StMemWb   = 4'd4;
    localparam logic [3:0] StMemWr   = 4'd5;
    localparam logic [3:0] StRtypeEx = 4'd6;
    localparam logic [3:0] StRtypeWb = 4'd7;
    localparam logic [3:0] StBeqEx   = 4'd8;
    localparam logic [3:0] StAddiEx  = 4'd9;
    localparam logic [3:0] StAddiWb  = 4'd10;
    localparam logic [3:0] StJEx     = 4'd11;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    logic [3:0] state_q, state_d;
    logic       op_mem, op_rtype, op_beq, op_addi, op_j, op_legal;
    logic       pc_write, branch;
    logic [1:0] alu_op;
    logic       mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

    assign op_mem   = (op == OpLw) || (op == OpSw);
    assign op_rtype = (op == OpRtype);
    assign op_beq   = (op == OpBeq);
    assign op_addi  = (ADDI_EN != 0) && (op == OpAddi);
    assign op_j     = (J_EN != 0) && (op == OpJ);
    assign op_legal = op_mem || op_rtype || op_beq || op_addi || op_j;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Codes 12-15 fall into the default arm and recover to FETCH.
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                if (op_mem)        state_d = StMemAdr;
                else if (op_rtype) state_d = StRtypeEx;
                else if (op_beq)   state_d = StBeqEx;
                else if (op_addi)  state_d = StAddiEx;
                else if (op_j)     state_d = StJEx;
                else               state_d = StFetch;
            end
            StMemAdr:  state_d = (op == OpLw) ? StMemRd : StMemWr;
            StMemRd:   state_d = StMemWb;
            StRtypeEx: state_d = StRtypeWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
    end

    always_comb begin
        i_or_d        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 2'b00;
        pc_write      = 1'b0;
        branch        = 1'b0;
        illegal_raw   = 1'b0;
        case (state_q)
            StFetch: begin
                ir_write_raw = 1'b1;
                pc_write     = 1'b1;
                alu_src_b    = 2'b01;
            end
            StDecode: begin
                alu_src_b   = 2'b11;
                illegal_raw = !op_legal;
            end
            StMemAdr, StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRd: i_or_d = 1'b1;
            StMemWb: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
            end
            StMemWr: begin
                i_or_d        = 1'b1;
                mem_write_raw = 1'b1;
            end
            StRtypeEx: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            StRtypeWb: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
            end
            StBeqEx: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 2'b01;
            end
            StAddiWb: reg_write_raw = 1'b1;
            StJEx: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_control = 3'b010;
        case (alu_op)
            2'b00: alu_control = 3'b010;
            2'b01: alu_control = 3'b110;
            default: begin
                case (funct)
                    6'b100000: alu_control = 3'b010;
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
            end
        endcase
    end

    // Enables are masked by reset so nothing fires while reset is held.
    assign mem_write = mem_write_raw & reset_n;
    assign ir_write  = ir_write_raw & reset_n;
    assign reg_write = reg_write_raw & reset_n;
    assign illegal   = illegal_raw & reset_n;
    assign pc_en     = (pc_write | (branch & zero)) & reset_n;
    assign state     = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Table-driven bench for mc_control_unit: per-cycle expected state and control word,
// plus directed sequences for reset behaviour and disabled opcodes.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;

    logic       i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       pc_en, illegal;
    logic [3:0] state;

    logic       n_i_or_d, n_mem_write, n_ir_write, n_reg_dst, n_mem_to_reg, n_reg_write;
    logic       n_alu_src_a, n_pc_en, n_illegal;
    logic [1:0] n_alu_src_b, n_pc_src;
    logic [2:0] n_alu_control;
    logic [3:0] n_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_control_unit dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src),
        .pc_en(pc_en), .illegal(illegal), .state(state)
    );

    mc_control_unit #(.ADDI_EN(0), .J_EN(0)) dut_nj (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .i_or_d(n_i_or_d), .mem_write(n_mem_write), .ir_write(n_ir_write),
        .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write),
        .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_control(n_alu_control),
        .pc_src(n_pc_src), .pc_en(n_pc_en), .illegal(n_illegal), .state(n_state)
    );

    // Control word: {i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
    //                alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal}
    logic [15:0] ctl;
    assign ctl = {i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, alu_control, pc_src, pc_en, illegal};

    function automatic logic [15:0] mk(input logic iod, input logic mw, input logic irw,
                                       input logic rd, input logic m2r, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [2:0] ac, input logic [1:0] ps,
                                       input logic pen, input logic ill);
        return {iod, mw, irw, rd, m2r, rw, asa, asb, ac, ps, pen, ill};
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [3:0]  st;
        logic [15:0] ctl;
    } vec_t;

    vec_t tbl[$];

    logic [15:0] c_fetch, c_dec, c_dec_ill, c_memadr, c_memrd, c_memwb, c_memwr;
    logic [15:0] c_rtwb, c_addiwb, c_jex, c_rst;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic [3:0] st, input logic [15:0] c);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.st = st; v.ctl = c;
        tbl.push_back(v);
    endtask

    task automatic add_rtype(input logic [5:0] f, input logic [2:0] ac);
        add(6'b000000, f, 1'b0, 4'd0, c_fetch);
        add(6'b000000, f, 1'b0, 4'd1, c_dec);
        add(6'b000000, f, 1'b0, 4'd6, mk(0, 0, 0, 0, 0, 0, 1, 2'b00, ac, 2'b00, 0, 0));
        add(6'b000000, f, 1'b0, 4'd7, c_rtwb);
    endtask

    task automatic add_beq(input logic z);
        add(6'b000100, 6'd0, z, 4'd0, c_fetch);
        add(6'b000100, 6'd0, z, 4'd1, c_dec);
        add(6'b000100, 6'd0, z, 4'd8, mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, z, 0));
    endtask

    // Holds reset 3 cycles, checking both instances, then releases just after a negedge.
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_ctl", ctl, c_rst);
            check("rst_state", {12'd0, state}, 16'd0);
            check("rst_nj", {11'd0, n_state, n_illegal}, 16'd0);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        c_fetch   = mk(0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 1, 0);
        c_dec     = mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 0);
        c_dec_ill = mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 1);
        c_memadr  = mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0);
        c_memrd   = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0);
        c_memwb   = mk(0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b010, 2'b00, 0, 0);
        c_memwr   = mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0, 0);
        c_rtwb    = mk(0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0, 0);
        c_addiwb  = mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0, 0);
        c_jex     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b10, 1, 0);
        c_rst     = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0, 0);

        add_rtype(6'b100000, 3'b010);
        add_rtype(6'b101010, 3'b111);
        add_rtype(6'b100100, 3'b000);
        add_rtype(6'b100101, 3'b001);
        add_rtype(6'b100010, 3'b110);
        add_rtype(6'b111111, 3'b010);
        add(6'b100011, 6'd0, 1'b0, 4'd0, c_fetch);
        add(6'b100011, 6'd0, 1'b0, 4'd1, c_dec);
        add(6'b100011, 6'd0, 1'b0, 4'd2, c_memadr);
        add(6'b100011, 6'd0, 1'b0, 4'd3, c_memrd);
        add(6'b100011, 6'd0, 1'b0, 4'd4, c_memwb);
        add(6'b101011, 6'd0, 1'b1, 4'd0, c_fetch);
        add(6'b101011, 6'd0, 1'b1, 4'd1, c_dec);
        add(6'b101011, 6'd0, 1'b1, 4'd2, c_memadr);
        add(6'b101011, 6'd0, 1'b1, 4'd5, c_memwr);
        add_beq(1'b1);
        add_beq(1'b0);
        add(6'b111111, 6'd0, 1'b0, 4'd0, c_fetch);
        add(6'b111111, 6'd0, 1'b0, 4'd1, c_dec_ill);
        add(6'b000010, 6'd0, 1'b0, 4'd0, c_fetch);
        add(6'b000010, 6'd0, 1'b0, 4'd1, c_dec);
        add(6'b000010, 6'd0, 1'b0, 4'd11, c_jex);
        add(6'b001000, 6'd0, 1'b0, 4'd0, c_fetch);
        add(6'b001000, 6'd0, 1'b0, 4'd1, c_dec);
        add(6'b001000, 6'd0, 1'b0, 4'd9, c_memadr);
        add(6'b001000, 6'd0, 1'b0, 4'd10, c_addiwb);
        add(6'b000000, 6'b100000, 1'b0, 4'd0, c_fetch);

        do_reset();

        foreach (tbl[i]) begin
            op = tbl[i].op;
            funct = tbl[i].funct;
            zero = tbl[i].zero;
            #1;
            check($sformatf("vec%0d_state", i), {12'd0, state}, {12'd0, tbl[i].st});
            check($sformatf("vec%0d_ctl", i), ctl, tbl[i].ctl);
            @(negedge clk);
        end

        // beq: pc_en tracks zero within the BEQEX cycle.
        do_reset();
        op = 6'b000100;
        zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("beq_pcen_z0", {15'd0, pc_en}, 16'd0);
        zero = 1'b1;
        #1;
        check("beq_pcen_z1", {15'd0, pc_en}, 16'd1);

        // lw reaches MEMWB, then asynchronous reset mid-cycle.
        do_reset();
        op = 6'b100011;
        repeat (4) @(negedge clk);
        #1;
        check("midrst_pre_state", {12'd0, state}, 16'd4);
        check("midrst_pre_rw", {15'd0, reg_write}, 16'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_state", {12'd0, state}, 16'd0);
        check("midrst_ctl", ctl, c_rst);

        // Disabled j and addi decode as illegal on the stripped instance.
        do_reset();
        op = 6'b000010;
        #1;
        check("nj_j_c0", {11'd0, n_state, n_illegal}, {11'd0, 4'd0, 1'b0});
        @(negedge clk);
        #1;
        check("nj_j_c1", {11'd0, n_state, n_illegal}, {11'd0, 4'd1, 1'b1});
        @(negedge clk);
        #1;
        check("nj_j_c2", {11'd0, n_state, n_illegal}, {11'd0, 4'd0, 1'b0});
        do_reset();
        op = 6'b001000;
        @(negedge clk);
        #1;
        check("nj_addi_c1", {11'd0, n_state, n_illegal}, {11'd0, 4'd1, 1'b1});
        check("nj_addi_main", {11'd0, state, illegal}, {11'd0, 4'd1, 1'b0});
        @(negedge clk);
        #1;
        check("nj_addi_c2", {11'd0, n_state, n_illegal}, {11'd0, 4'd0, 1'b0});
        check("nj_addi_main2", {12'd0, state}, 16'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle MIPS control unit: Moore FSM (main controller) plus combinational ALU decoder.
- Consumes op/funct from the instruction register and zero from the ALU.
- Drives every select and enable of the multicycle datapath: memory, IR, register file, ALU source muxes, PC mux and PC enable.
- Sits directly upstream of the datapath's ALU, muxes, register file and memory.

Parameters:
- ADDI_EN, 1, 1 = addi supported; 0 = opcode 001000 treated as illegal.
- J_EN, 1, 1 = j supported; 0 = opcode 000010 treated as illegal.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register enable.
- reg_dst  out  1  write register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = Data.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2.
- alu_control  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt.
- pc_src  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  pc_write | (branch & zero).
- illegal  out  1  one-cycle pulse in DECODE on an unsupported op.
- state  out  4  current state (debug).

Behaviour:
- State register is the only storage.
  - reset_n low: state <= FETCH asynchronously.
  - Otherwise it updates on rising clk.
- Outputs are combinational from state only (Moore), except:
  - pc_en uses zero;
  - alu_control uses funct when alu_op = 10.
- While reset_n = 0, force mem_write, ir_write, reg_write, pc_en and illegal to 0; selects take their FETCH values.
- Signals not listed in a state are 0; alu_op defaults to 00.
- State encodings and outputs:
  - FETCH 0: ir_write, pc_write, alu_src_b = 01, alu_op 00 → PC+4. Next: DECODE.
  - DECODE 1: alu_src_b = 11, alu_op 00 (branch target). Next state by op:
    - 100011 / 101011 → MEMADR.
    - 000000 → RTYPEEX.
    - 000100 → BEQEX.
    - 001000 → ADDIEX (if ADDI_EN).
    - 000010 → JEX (if J_EN).
    - Anything else → FETCH, with illegal = 1.
  - MEMADR 2: alu_src_a = 1, alu_src_b = 10. Next: MEMRD if op = 100011, else MEMWR.
  - MEMRD 3: i_or_d = 1. Next: MEMWB.
  - MEMWB 4: reg_write, mem_to_reg = 1, reg_dst = 0. Next: FETCH.
  - MEMWR 5: i_or_d = 1, mem_write. Next: FETCH.
  - RTYPEEX 6: alu_src_a = 1, alu_src_b = 00, alu_op 10. Next: RTYPEWB.
  - RTYPEWB 7: reg_write, reg_dst = 1, mem_to_reg = 0. Next: FETCH.
  - BEQEX 8: alu_src_a = 1, alu_src_b = 00, alu_op 01, branch = 1, pc_src = 01. Next: FETCH.
  - ADDIEX 9: alu_src_a = 1, alu_src_b = 10, alu_op 00. Next: ADDIWB.
  - ADDIWB 10: reg_write, reg_dst = 0, mem_to_reg = 0. Next: FETCH.
  - JEX 11: pc_write, pc_src = 10. Next: FETCH.
  - Codes 12–15 are unreachable. If entered, go to FETCH next cycle with all enables 0.
- ALU decoder:
  - alu_op 00 → 010.
  - alu_op 01 → 110.
  - alu_op 10 by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111, other → 010.
- Per-instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- op and funct are sampled only in DECODE, MEMADR and RTYPEEX. The IR is stable there because ir_write is asserted only in FETCH.
- pc_en in BEQEX follows zero combinationally within the same cycle.
- Reset mid-instruction: state returns to FETCH at once and no partial write enable is asserted.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles, then release → state = 0; during reset all enables are 0. First post-reset cycle: ir_write = 1, pc_en = 1, alu_src_b = 01.
- R-type add then slt: op = 000000, funct = 100000 → states 0,1,6,7; alu_control = 010 in state 6; reg_write = 1 with reg_dst = 1 in state 7. Repeat with funct = 101010 → alu_control = 111.
- lw / sw: op = 100011 → states 0,1,2,3,4; i_or_d = 1 in 3; reg_write = 1 with mem_to_reg = 1 in 4. op = 101011 → states 0,1,2,5; mem_write = 1 only in 5.
- beq: op = 000100 with zero = 1 → pc_en = 1, pc_src = 01, alu_control = 110 in state 8. With zero = 0 → pc_en = 0. Both return to FETCH.
- Illegal / disabled op: op = 111111 → illegal = 1 for exactly one cycle in state 1, then state 0. With J_EN = 0, op = 000010 behaves the same way. With J_EN = 1 → states 0,1,11 with pc_src = 10.
- Reset mid-op: pull reset_n low asynchronously in state 4 (MEMWB) → reg_write drops immediately and state = 0 without a clock edge.
